commit_write_sequencer: RTL

//  Sits between the ROB commit stage and the rename unit's single ARF write-back port.

---
 rtl/commit_write_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/commit_write_sequencer.sv
// Commit write sequencer: buffers up to two committing instructions per cycle in order and
// drains them so the ARF sees at most one write per cycle, reporting released RRF entries.
module commit_write_sequencer #(
    parameter int DEPTH     = 4,
    parameter int REG_SEL_W = 5,
    parameter int RRF_SEL_W = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 commit1_valid_i,
    input  logic                 commit1_dst_en_i,
    input  logic [REG_SEL_W-1:0] commit1_dstnum_i,
    input  logic [RRF_SEL_W-1:0] commit1_rrftag_i,
    input  logic                 commit2_valid_i,
    input  logic                 commit2_dst_en_i,
    input  logic [REG_SEL_W-1:0] commit2_dstnum_i,
    input  logic [RRF_SEL_W-1:0] commit2_rrftag_i,
    output logic                 commit_ready_o,
    output logic                 completed_we_o,
    output logic [REG_SEL_W-1:0] completed_dstnum_o,
    output logic [RRF_SEL_W-1:0] completed_dst_rrftag_o,
    output logic [1:0]           com_inst_num_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    function automatic logic wr_flag(input logic en, input logic [REG_SEL_W-1:0] dstnum);
        return en & (dstnum != '0);
    endfunction

    logic [REG_SEL_W-1:0] dst_mem [DEPTH];
    logic [RRF_SEL_W-1:0] tag_mem [DEPTH];
    logic                 w_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_p0, rd_ptr_p0;
    logic [CNT_W-1:0] count_p0;

    logic             push_one, push_two;
    logic [1:0]       push_num;
    logic             drain_one, drain_two;
    logic [1:0]       drain_num;
    logic [PTR_W-1:0] wr_ptr_inc, rd_ptr_inc;
    logic             w_head, w_next;
    logic             out_we;
    logic             out_sel_head, out_sel_next;

    logic                 we_p1;
    logic [REG_SEL_W-1:0] dstnum_p1;
    logic [RRF_SEL_W-1:0] rrftag_p1;
    logic [1:0]           num_p1;

    assign commit_ready_o = (count_p0 <= READY_MAX);
    assign busy_o         = (count_p0 != '0);

    assign push_one = commit_ready_o & commit1_valid_i;
    assign push_two = push_one & commit2_valid_i;
    assign push_num = {1'b0, push_one} + {1'b0, push_two};

    assign wr_ptr_inc = wr_ptr_p0 + PTR_W'(1);
    assign rd_ptr_inc = rd_ptr_p0 + PTR_W'(1);

    assign w_head = w_mem[rd_ptr_p0];
    assign w_next = w_mem[rd_ptr_inc];

    // Pair drain only when the two entries together need at most one ARF write.
    assign drain_one = (count_p0 != '0);
    assign drain_two = (count_p0 >= CNT_TWO) & ~(w_head & w_next);
    assign drain_num = drain_two ? 2'd2 : (drain_one ? 2'd1 : 2'd0);

    assign out_sel_head = drain_one & w_head;
    assign out_sel_next = drain_two & w_next;
    assign out_we       = out_sel_head | out_sel_next;

    // Stage p0: FIFO storage (data only, no reset needed)
    always_ff @(posedge clk_i) begin
        if (push_one) begin
            dst_mem[wr_ptr_p0] <= commit1_dstnum_i;
            tag_mem[wr_ptr_p0] <= commit1_rrftag_i;
            w_mem[wr_ptr_p0]   <= wr_flag(commit1_dst_en_i, commit1_dstnum_i);
        end
        if (push_two) begin
            dst_mem[wr_ptr_inc] <= commit2_dstnum_i;
            tag_mem[wr_ptr_inc] <= commit2_rrftag_i;
            w_mem[wr_ptr_inc]   <= wr_flag(commit2_dst_en_i, commit2_dstnum_i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            wr_ptr_p0 <= wr_ptr_p0 + PTR_W'(push_num);
            rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(drain_num);
            count_p0  <= count_p0 + CNT_W'(push_num) - CNT_W'(drain_num);
        end
    end

    // Stage p1: registered ARF write and release count
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_p1     <= 1'b0;
            dstnum_p1 <= '0;
            rrftag_p1 <= '0;
            num_p1    <= 2'd0;
        end else begin
            we_p1  <= out_we;
            num_p1 <= drain_num;
            if (out_sel_head) begin
                dstnum_p1 <= dst_mem[rd_ptr_p0];
                rrftag_p1 <= tag_mem[rd_ptr_p0];
            end else if (out_sel_next) begin
                dstnum_p1 <= dst_mem[rd_ptr_inc];
                rrftag_p1 <= tag_mem[rd_ptr_inc];
            end
        end
    end

    assign completed_we_o         = we_p1;
    assign completed_dstnum_o     = dstnum_p1;
    assign completed_dst_rrftag_o = rrftag_p1;
    assign com_inst_num_o         = num_p1;

endmodule
